// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word with its PC for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          WORD_ADS     = 1'b1,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_ads,
    input  logic [31:0] imem_dout,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] ir_pc4,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] fetch_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        acc;
    logic        halt_word;

    // Handshake: ir/ir_pc transfer to decode on any edge where ir_valid && ir_ready.
    // ir_valid never drops without a transfer except on a redirect squash or reset,
    // and the register may be refilled on the same edge it is consumed.
    assign acc       = !ir_valid || ir_ready;
    assign halt_word = HALT_ON_ZERO && (imem_dout == 32'h0000_0000);

    assign imem_ads  = WORD_ADS ? {2'b00, pc[31:2]} : pc;
    assign ir_pc4    = ir_pc + 32'd4;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= 32'h0000_0000;
            ir_pc       <= 32'h0000_0000;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else begin
            misalign <= 1'b0;
            if (redirect) begin
                // Redirect wins over stall and halt; the in-flight ir is wrong-path.
                pc       <= {redirect_pc[31:2], 2'b00};
                ir_valid <= 1'b0;
                misalign <= |redirect_pc[1:0];
                halted   <= 1'b0;
                state    <= RUN;
            end else begin
                case (state)
                    IDLE: state <= RUN;
                    RUN: begin
                        if (acc) begin
                            if (halt_word) begin
                                state  <= HALT;
                                halted <= 1'b1;
                                if (ir_ready) ir_valid <= 1'b0;
                            end else begin
                                ir          <= imem_dout;
                                ir_pc       <= pc;
                                ir_valid    <= 1'b1;
                                pc          <= pc + 32'd4;
                                fetch_count <= fetch_count + 32'd1;
                            end
                        end
                    end
                    HALT: begin
                        if (ir_ready) ir_valid <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage placed directly upstream of the instruction memory and downstream of it for the instruction register (IR). It holds the program counter and drives the memory word address. Each accepted cycle it captures the combinational instruction word, together with its PC, into an output register. It hands that register to decode with a valid/ready handshake, and supports branch/jump redirect, backpressure stall and halt on an empty (all-zero) word.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset (bits [1:0] must be 0)
WORD_ADS, 1, 1: imem_ads = {2'b00, pc[31:2]} (word index into instruction array); 0: imem_ads = pc
HALT_ON_ZERO, 1, 1: fetching 32'h0000_0000 stops the stage; 0: zero word issued as normal

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_ads  output  32  address to instruction memory, combinational from pc
imem_dout  input  32  instruction word returned combinationally for imem_ads
redirect  input  1  branch/jump taken, load redirect_pc
redirect_pc  input  32  target byte address
ir_valid  output  1  ir/ir_pc hold a valid instruction
ir_ready  input  1  decode accepts ir this cycle
ir  output  32  registered instruction word
ir_pc  output  32  byte PC of ir
ir_pc4  output  32  ir_pc + 4 (link value for JAL/JALR), combinational from ir_pc
halted  output  1  stage is in HALT
misalign  output  1  one-cycle pulse: redirect_pc[1:0] != 0
fetch_count  output  32  number of instructions issued to ir since reset

Behaviour:
- Reset (sampled high at edge): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, misalign=0, fetch_count=0, state=IDLE. Reset overrides every other input.
- States: IDLE, RUN, HALT.
- IDLE: no capture; next state RUN unconditionally, unless redirect=1, in which case pc=redirect_pc and the next state is still RUN.
- RUN, accept condition acc = !ir_valid || ir_ready.
  - acc and no redirect and not a halt word: ir<=imem_dout, ir_pc<=pc, ir_valid<=1, pc<=pc+4, fetch_count+1.
  - !acc (ir_valid && !ir_ready): pc, ir, ir_pc, ir_valid, fetch_count all hold; memory output ignored.
  - ir_ready=1 while a new capture happens: old ir consumed and new ir loaded in the same edge (one instruction per cycle throughput).
  - ir_valid=1 and ir_ready=1 but no capture (halt word): ir_valid<=0.
- Halt word: when HALT_ON_ZERO=1, acc=1 and imem_dout==0, the word is not captured and pc holds. The stage goes to HALT with halted<=1; a pending ir is cleared only if ir_ready=1.
- HALT: pc frozen, no capture, halted=1. A pending ir_valid drains normally on ir_ready. Redirect leaves HALT to RUN with halted<=0.
- Redirect (any state but reset) has highest priority:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - ir_valid<=0 (squash), whether or not ir_ready is high and whether or not the stage is stalled.
  - No capture that cycle and fetch_count unchanged.
  - The first instruction from the target appears in ir one cycle later (redirect penalty = 1 bubble).
- misalign=1 for exactly the cycle after a redirect with redirect_pc[1:0]!=0; otherwise 0.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000. ir_pc4 wraps identically.
- fetch_count wraps modulo 2^32.
- Latency: reset released at edge N; IDLE during cycle N; first capture at edge N+1; ir_valid=1 from cycle N+1 onward.

Test Plan:
- Sequential fetch: memory words 0..3 = 0x00808493, 0x40140533, 0x00300593, 0x00000013, ir_ready=1, HALT_ON_ZERO=0. After reset, ir on consecutive cycles = those words with ir_pc = 0,4,8,12 and imem_ads = 0,1,2,3. fetch_count=4 after 4 captures.
- Backpressure: hold ir_ready=0 for 3 cycles after the first capture. ir=0x00808493, ir_pc=0 and pc=4 stay stable. On ir_ready=1, ir_pc=4 next cycle with no instruction lost or duplicated.
- Redirect: at ir_pc=4 assert redirect with redirect_pc=0x20 for one cycle. The next cycle has ir_valid=0; the following cycle has ir_pc=0x20, ir=mem[8]; fetch_count is unchanged during the bubble.
- Redirect while stalled plus misalign: ir_ready=0, ir_valid=1, redirect_pc=0x23. The pending ir is squashed; pc=0x20; misalign pulses for one cycle; the next ir_pc=0x20.
- Halt: HALT_ON_ZERO=1 and mem[2]=0. Stage captures ir_pc=0 and 4, then halted=1 with pc=8 frozen. A redirect to 0 restarts from ir_pc=0 with halted=0.
- Wrap/reset: RESET_PC=0xFFFF_FFFC. First ir_pc=0xFFFF_FFFC with ir_pc4=0, next ir_pc=0. Asserting reset mid-stream clears ir_valid and fetch_count on the next edge and sets pc=RESET_PC.
